// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand entry sequencer.
package alu_pkg;

    localparam int unsigned DATA_W                  = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, saturating-count debounce
// and a registered one-cycle strobe on each accepted press.
module btn_debounce
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d_q;
    logic             pulse_q;

    // Synchronizer: only sync_q[1] is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    // Level flips once the synced input has disagreed long enough; counter stops at CNT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Rising-edge strobe of the debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            level_d_q <= level_q;
            pulse_q   <= level_q & ~level_d_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects operand A, operand B and opcode from a switch nibble, one enter
// press per field, and presents them to the ALU once all three are committed.
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_enter,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] alu_op,
    output logic              operands_valid,
    output logic              valid_pulse,
    output logic [1:0]        stage
);

    logic enter_pulse;
    logic clear_pulse;

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic              valid_q;
    logic              vpulse_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_enter),
        .pulse (enter_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .pulse (clear_pulse)
    );

    // Next-state and field loads; clear takes priority over enter.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clear_pulse) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (enter_pulse) begin
            case (state_q)
                LOAD_A: begin
                    a_d     = sw;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    b_d     = sw;
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    op_d    = sw;
                    state_d = READY;
                end
                READY: begin
                    state_d = LOAD_A;
                end
                default: begin
                    state_d = LOAD_A;
                end
            endcase
        end
    end

    // State, fields and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            valid_q  <= 1'b0;
            vpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            valid_q  <= (state_d == READY);
            vpulse_q <= (state_d == READY) && (state_q != READY);
        end
    end

    assign operand_a      = a_q;
    assign operand_b      = b_q;
    assign alu_op         = op_q;
    assign operands_valid = valid_q;
    assign valid_pulse    = vpulse_q;
    assign stage          = 2'(state_q);

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed plus randomized bench for alu_input_sequencer with a short debounce.
module tb_alu_input_sequencer;

    localparam int unsigned DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [3:0] alu_op;
    logic       operands_valid;
    logic       valid_pulse;
    logic [1:0] stage;

    int checks = 0;
    int errors = 0;

    // Reference model: field values and the index of the field awaited next.
    int         m_state;
    logic [3:0] m_a, m_b, m_op;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .btn_enter      (btn_enter),
        .btn_clear      (btn_clear),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .alu_op         (alu_op),
        .operands_valid (operands_valid),
        .valid_pulse    (valid_pulse),
        .stage          (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = 4'h0;
        m_b = 4'h0;
        m_op = 4'h0;
    endtask

    task automatic model_apply(input bit e, input bit c, input logic [3:0] v, output int exp_vp);
        exp_vp = 0;
        if (c) begin
            model_reset();
        end else if (e) begin
            if (m_state == 0) m_a = v;
            if (m_state == 1) m_b = v;
            if (m_state == 2) begin
                m_op = v;
                exp_vp = 1;
            end
            m_state = (m_state + 1) % 4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/stage"}, 32'(stage), 32'(m_state));
        chk({tag, "/a"}, 32'(operand_a), 32'(m_a));
        chk({tag, "/b"}, 32'(operand_b), 32'(m_b));
        chk({tag, "/op"}, 32'(alu_op), 32'(m_op));
        chk({tag, "/valid"}, 32'(operands_valid), 32'(m_state == 3));
    endtask

    // Release both buttons and let the debouncers settle, wiggling sw meanwhile.
    task automatic release_and_idle(inout int vp);
        @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sw = 4'($urandom);
            @(posedge clk);
            #1;
            if (valid_pulse === 1'b1) vp++;
        end
    endtask

    task automatic press(input bit e, input bit c, input logic [3:0] v, input string tag);
        int vp;
        int exp_vp;
        vp = 0;
        @(negedge clk);
        sw = v;
        btn_enter = e;
        btn_clear = c;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid_pulse === 1'b1) vp++;
        end
        release_and_idle(vp);
        model_apply(e, c, v, exp_vp);
        check_all(tag);
        chk({tag, "/vpulse"}, 32'(vp), 32'(exp_vp));
    endtask

    // Enter press with latency measurement from the first edge sampling a stable high.
    task automatic press_timed(input bit bounce, input logic [3:0] v, input string tag);
        logic [1:0] old;
        bit         pat [5];
        int         k;
        int         vp;
        int         exp_vp;
        bit         done;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        old = stage;
        vp = 0;
        done = 1'b0;
        model_apply(1'b1, 1'b0, v, exp_vp);
        @(negedge clk);
        sw = v;
        if (bounce) begin
            for (int i = 0; i < 5; i++) begin
                btn_enter = pat[i];
                @(negedge clk);
            end
        end
        btn_enter = 1'b1;
        @(posedge clk);
        k = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (valid_pulse === 1'b1) vp++;
            if (stage !== old) begin
                done = 1'b1;
                chk({tag, "/valid_at_change"}, 32'(operands_valid), 32'(m_state == 3));
            end
        end
        chk({tag, "/latency"}, 32'(k), 32'(DEB + 4));
        repeat (4) begin
            @(posedge clk);
            #1;
            if (valid_pulse === 1'b1) vp++;
        end
        release_and_idle(vp);
        check_all(tag);
        chk({tag, "/vpulse"}, 32'(vp), 32'(exp_vp));
    endtask

    initial begin
        int vp;
        int exp_vp;
        int r;

        rst_n = 1'b0;
        sw = 4'h0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset/vpulse", 32'(valid_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full entry sequence.
        press(1'b1, 1'b0, 4'h3, "entry_a");
        press(1'b1, 1'b0, 4'h5, "entry_b");
        press(1'b1, 1'b0, 4'h1, "entry_op");

        // READY + enter returns to LOAD_A keeping the fields.
        press_timed(1'b0, 4'hE, "ready_exit");

        // Bouncy enter in LOAD_A.
        press_timed(1'b1, 4'hA, "bounce");

        // Short glitches must be ignored.
        for (int len = 1; len < int'(DEB); len++) begin
            @(negedge clk);
            btn_enter = 1'b1;
            repeat (len) @(negedge clk);
            btn_enter = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            check_all("glitch");
        end

        // Clear in LOAD_OP.
        press(1'b0, 1'b1, 4'h0, "clr0");
        press(1'b1, 1'b0, 4'h9, "clr_a");
        press(1'b1, 1'b0, 4'h6, "clr_b");
        press(1'b0, 1'b1, 4'hF, "clr_loadop");

        // Simultaneous enter and clear in READY.
        press(1'b1, 1'b0, 4'h2, "sim_a");
        press(1'b1, 1'b0, 4'h4, "sim_b");
        press(1'b1, 1'b0, 4'h8, "sim_op");
        press(1'b1, 1'b1, 4'h7, "sim_both");

        // Asynchronous reset while in LOAD_B.
        press(1'b1, 1'b0, 4'h7, "areset_a");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset/a_async", 32'(operand_a), 32'd0);
        chk("areset/stage_async", 32'(stage), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vp = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid_pulse === 1'b1) vp++;
        end
        check_all("areset");
        chk("areset/vpulse", 32'(vp), 32'd0);

        // Button held through reset yields exactly one press afterwards.
        @(negedge clk);
        sw = 4'hC;
        btn_enter = 1'b1;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        sw = 4'hD;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (14) @(posedge clk);
        #1;
        model_apply(1'b1, 1'b0, 4'hD, exp_vp);
        check_all("held_reset");
        vp = 0;
        release_and_idle(vp);
        check_all("held_reset_rel");

        // Randomized operation mix.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      press(1'b1, 1'b0, 4'($urandom), "rnd_enter");
            else if (r < 9) press(1'b0, 1'b1, 4'($urandom), "rnd_clear");
            else            press(1'b1, 1'b1, 4'($urandom), "rnd_both");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sw  input  4  raw switch nibble, the operand/opcode value being entered.
REQ-005 btn_enter  input  1  raw, bouncing, asynchronous "accept value" button.
REQ-006 btn_clear  input  1  raw, bouncing, asynchronous "abort/clear" button.
REQ-007 operand_a  output  4  latched A operand to the ALU.
REQ-008 operand_b  output  4  latched B operand to the ALU.
REQ-009 alu_op  output  4  latched opcode to the ALU.
REQ-010 operands_valid  output  1  high while all three fields are committed (READY state).
REQ-011 valid_pulse  output  1  one-cycle strobe on entry to READY.
REQ-012 stage  output  2  current state encoding, for LED display.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounced level SHALL toggle only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter to 0.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap.
REQ-016 Press pulse SHALL be registered, high exactly one cycle per debounced 0->1 transition; release produces no pulse.
REQ-017 With a clean raw edge, press pulse SHALL assert exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge sampling raw high.
REQ-018 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse.
REQ-019 FSM states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3; stage SHALL equal the encoding.
REQ-020 LOAD_A + enter pulse: operand_a <= sw, -> LOAD_B.
REQ-021 LOAD_B + enter pulse: operand_b <= sw, -> LOAD_OP.
REQ-022 LOAD_OP + enter pulse: alu_op <= sw, -> READY; valid_pulse high in the first READY cycle only.
REQ-023 READY + enter pulse: -> LOAD_A, operands_valid drops next cycle; latched fields retained until overwritten.
REQ-024 Clear pulse in any state: -> LOAD_A, all three fields <= 0, operands_valid <= 0.
REQ-025 Simultaneous enter and clear pulses: clear wins; no field loads.
REQ-026 sw SHALL be sampled only in the enter-pulse cycle; sw changes at other times SHALL not affect outputs.
REQ-027 operands_valid SHALL be a registered output equal to (state == READY).

Reset
REQ-028 rst_n low SHALL asynchronously force: state LOAD_A, operand_a/operand_b/alu_op 0, operands_valid 0, valid_pulse 0, synchronizers/debounced levels/counters 0.
REQ-029 Reset deassertion while a button is held SHALL not generate a pulse until the button is released and pressed again only if held level was already 1 at debounce completion; a held button yields exactly one pulse after DEBOUNCE_CYCLES+3 cycles.
REQ-030 Reset mid-entry SHALL discard partial fields; no valid_pulse on exit from reset.

Structure
REQ-031 Shared package alu_pkg SHALL hold the state enum (seq_state_t), DEBOUNCE_CYCLES default, and the 4-bit width constant.
REQ-032 One sub-module, btn_debounce (sync + debounce + pulse), SHALL be instantiated twice; FSM and field registers live in the top.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Enter with sw=3, then sw=5, then sw=0001 -> operand_a=3, operand_b=5, alu_op=1, operands_valid=1, valid_pulse one cycle, stage=3.
REQ-034 btn_enter bounce pattern 1,0,1,1,0 then stable 1 for 10 cycles -> exactly one pulse, 7 cycles after stable high begins, stage 0->1.
REQ-035 Clear in LOAD_OP after A=9, B=6 -> all fields 0, stage=0, operands_valid=0.
REQ-036 Enter and clear raw edges identical in READY -> stage=0, fields 0, no valid_pulse.
REQ-037 rst_n low for 1 cycle while in LOAD_B with A=7 -> operand_a=0 immediately (async), stage=0.
REQ-038 READY then enter -> stage=0, operands_valid=0 next cycle, operand_a/b/alu_op unchanged until reloaded.
